mod_envelope_gen: RTL and testbench
===================================

// Module: mod_envelope_gen
// PURPOSE
//  ADSR envelope generator producing a fixed-point gain in [0, 1.0] once per sample tick.
//  Sits directly upstream of the fixed-point multiplier: o_level drives one multiplicand, the
//  oscillator sample drives the other. Same Q format as the multiplier (WIDTH total, POINT frac).
//  Sequential 5-state FSM; one level update per i_tick strobe.
// PARAMETERS
//  WIDTH  32  total bits of every level/step port (unsigned fixed point)
//  POINT  8   fractional bits; unity gain ONE = 1 << POINT
// PORTS
//  i_clk      in   1      clock
//  i_rst_n    in   1      asynchronous active-low reset
//  i_tick     in   1      sample strobe; one envelope step per high cycle
//  i_gate     in   1      note on (1) / off (0); sampled only on i_tick cycles
//  i_attack   in   WIDTH  level increment per tick in ATTACK (0 = instant)
//  i_decay    in   WIDTH  level decrement per tick in DECAY (0 = instant)
//  i_sustain  in   WIDTH  sustain level; values > ONE treated as ONE
//  i_release  in   WIDTH  level decrement per tick in RELEASE (0 = instant)
//  o_level    out  WIDTH  current envelope gain, Q(WIDTH-POINT).POINT
//  o_valid    out  1      one-cycle pulse: o_level updated this cycle
//  o_state    out  3      current state (package enum), for debug/voice allocation
//  o_active   out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state IDLE, o_level 0, o_valid 0, o_active 0, gate_q 0.
//    Reset mid-envelope aborts immediately; no release tail.
//  - Latency: i_tick at cycle N -> new o_level and o_valid=1 at cycle N+1. No tick -> all hold.
//  - Gate edges detected on ticks only: rise = i_gate & ~gate_q; gate_q <= i_gate on tick.
//  - Transitions (evaluated on tick; edge has priority over step progression):
//      gate rise, any state      -> ATTACK, step from current level (no reset to 0).
//      gate fall, ATT/DEC/SUS    -> RELEASE, step from current level same tick.
//      ATTACK : lvl+i_attack >= ONE or i_attack==0 -> lvl=ONE, DECAY.
//      DECAY  : lvl-i_decay <= sus or i_decay==0   -> lvl=sus, SUSTAIN.
//      SUSTAIN: lvl=sus (tracks i_sustain changes on each tick).
//      RELEASE: lvl<=i_release or i_release==0     -> lvl=0, IDLE.
//      IDLE   : lvl=0.
//  - Edge applies same tick as step: rise in RELEASE at lvl 100, attack 64 -> ATTACK, lvl 164.
//  - Arithmetic: unsigned, computed at WIDTH+1 bits, saturated to [0, ONE]; never wraps.
//  - sus = min(i_sustain, ONE). sus==ONE: DECAY exits on the first tick.
//  - o_valid pulses on every tick, IDLE included; i_tick held high = step every cycle.
//  - Step inputs are sampled on the tick cycle; changes between ticks have no effect.
// STRUCTURE
//  - Package pkg_envelope: typedef enum logic [2:0] {ENV_IDLE, ENV_ATTACK, ENV_DECAY,
//    ENV_SUSTAIN, ENV_RELEASE} env_state_t; function env_one(POINT) returning 1 << POINT.
//  - Sub-module mod_sat_step: combinational saturating add/sub of step toward a bound
//    (inputs level, step, bound, dir; outputs next, reached). Instantiated once, muxed by state.
//  - FSM + level register + gate_q + valid register in this module.
// TESTING (WIDTH=32, POINT=8, ONE=256)
//  - attack=64, gate=1, 4 ticks -> o_level 64,128,192,256; state DECAY after tick 4; o_valid per tick.
//  - decay=32, sustain=200 from 256 -> 224, 200 (clamped), state SUSTAIN; level holds 200 over ticks.
//  - release=100, gate=0 at lvl 200 -> 100, 0, state IDLE, o_active=0 on the same update.
//  - Retrigger: gate=1 at lvl 100 in RELEASE, attack=64 -> next tick lvl 164, state ATTACK.
//  - Edge cases: i_attack=0 -> 256 in one tick; i_sustain=300 -> sustains at 256; gate toggle without tick -> no change.
//  - Async reset asserted mid-ATTACK (lvl 128, no clock edge) -> o_level 0, IDLE, o_valid 0 immediately.

Source files
------------

// File: rtl/mod_envelope_gen_pkg.sv
// Package for the ADSR envelope generator.
// Provides the FSM state enumeration shared by the generator, its debug port
// and any voice allocator, plus a helper that returns unity gain for a given
// number of fractional bits.
package pkg_envelope;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    // Unity gain (1.0) in a fixed-point format with 'point' fractional bits.
    function automatic logic [63:0] env_one(input int unsigned point);
        return 64'd1 << point;
    endfunction

endpackage

// File: rtl/mod_envelope_gen_sat_step.sv
// Combinational saturating step of a level toward a bound.
// Ports:
//   level   in   WIDTH  current level
//   step    in   WIDTH  step size (0 means jump straight to the bound)
//   bound   in   WIDTH  target level the step must not cross
//   dir     in   1      1 = step upward, 0 = step downward
//   next    out  WIDTH  stepped level, clamped to bound
//   reached out  1      bound hit or crossed this step (or step is 0)
module mod_sat_step
    import pkg_envelope::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] bound,
    input  logic             dir,
    output logic [WIDTH-1:0] next,
    output logic             reached
);

    // One extra bit so the sum cannot wrap and the difference exposes a borrow.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, level} + {1'b0, step};
        diff = {1'b0, level} - {1'b0, step};
        if (dir) begin
            reached = (step == '0) || (sum >= {1'b0, bound});
        end else begin
            // A borrow means the result went below zero, hence below any bound.
            reached = (step == '0) || diff[WIDTH] || (diff[WIDTH-1:0] <= bound);
        end
        if (reached) begin
            next = bound;
        end else if (dir) begin
            next = sum[WIDTH-1:0];
        end else begin
            next = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_envelope_gen.sv
// ADSR envelope generator: produces a fixed-point gain in [0, 1.0] that is
// updated once per sample tick and feeds one multiplicand of the downstream
// fixed-point multiplier.
// Ports:
//   i_clk      in   1      clock
//   i_rst_n    in   1      asynchronous active-low reset
//   i_tick     in   1      sample strobe, one envelope step per high cycle
//   i_gate     in   1      note on/off, only looked at on tick cycles
//   i_attack   in   WIDTH  level increment per tick in ATTACK (0 = instant)
//   i_decay    in   WIDTH  level decrement per tick in DECAY (0 = instant)
//   i_sustain  in   WIDTH  sustain level, clamped to 1.0
//   i_release  in   WIDTH  level decrement per tick in RELEASE (0 = instant)
//   o_level    out  WIDTH  envelope gain, POINT fractional bits
//   o_valid    out  1      pulses the cycle after each tick
//   o_state    out  3      current env_state_t
//   o_active   out  1      high whenever the state is not IDLE
module mod_envelope_gen
    import pkg_envelope::*;
#(
    parameter int WIDTH = 32,
    parameter int POINT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_gate,
    input  logic [WIDTH-1:0] i_attack,
    input  logic [WIDTH-1:0] i_decay,
    input  logic [WIDTH-1:0] i_sustain,
    input  logic [WIDTH-1:0] i_release,
    output logic [WIDTH-1:0] o_level,
    output logic             o_valid,
    output logic [2:0]       o_state,
    output logic             o_active
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(env_one(POINT));

    env_state_t       state_p1;
    env_state_t       act_state;
    env_state_t       state_p0;
    logic [WIDTH-1:0] level_p1;
    logic [WIDTH-1:0] level_p0;
    logic [WIDTH-1:0] sus;
    logic [WIDTH-1:0] step_sel;
    logic [WIDTH-1:0] bound_sel;
    logic [WIDTH-1:0] step_next;
    logic             dir_sel;
    logic             step_reached;
    logic             gate_q;
    logic             rise;
    logic             fall;
    logic             vld_p1;
    logic             active_p1;

    function automatic logic [WIDTH-1:0] clamp_one(input logic [WIDTH-1:0] x);
        return (x > ONE) ? ONE : x;
    endfunction

    mod_sat_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .level  (level_p1),
        .step   (step_sel),
        .bound  (bound_sel),
        .dir    (dir_sel),
        .next   (step_next),
        .reached(step_reached)
    );

    // Stage p0: gate edges pick the state whose step rule applies this tick,
    // so a retrigger or note-off takes effect on the same update.
    always_comb begin
        sus  = clamp_one(i_sustain);
        rise = i_gate & ~gate_q;
        fall = ~i_gate & gate_q;

        act_state = state_p1;
        if (rise) begin
            act_state = ENV_ATTACK;
        end else if (fall && (state_p1 == ENV_ATTACK || state_p1 == ENV_DECAY ||
                              state_p1 == ENV_SUSTAIN)) begin
            act_state = ENV_RELEASE;
        end

        step_sel  = i_release;
        bound_sel = '0;
        dir_sel   = 1'b0;
        case (act_state)
            ENV_ATTACK: begin
                step_sel  = i_attack;
                bound_sel = ONE;
                dir_sel   = 1'b1;
            end
            ENV_DECAY: begin
                step_sel  = i_decay;
                bound_sel = sus;
            end
            default: ;
        endcase

        state_p0 = act_state;
        level_p0 = level_p1;
        case (act_state)
            ENV_IDLE: level_p0 = '0;
            ENV_ATTACK: begin
                level_p0 = step_next;
                if (step_reached) state_p0 = ENV_DECAY;
            end
            ENV_DECAY: begin
                level_p0 = step_next;
                if (step_reached) state_p0 = ENV_SUSTAIN;
            end
            ENV_SUSTAIN: level_p0 = sus;
            ENV_RELEASE: begin
                level_p0 = step_next;
                if (step_reached) state_p0 = ENV_IDLE;
            end
            default: begin
                level_p0 = '0;
                state_p0 = ENV_IDLE;
            end
        endcase
    end

    // Stage p1: registered outputs, updated only on ticks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p1  <= ENV_IDLE;
            level_p1  <= '0;
            gate_q    <= 1'b0;
            vld_p1    <= 1'b0;
            active_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_tick;
            if (i_tick) begin
                gate_q    <= i_gate;
                state_p1  <= state_p0;
                level_p1  <= level_p0;
                active_p1 <= (state_p0 != ENV_IDLE);
            end
        end
    end

    assign o_level  = level_p1;
    assign o_valid  = vld_p1;
    assign o_state  = state_p1;
    assign o_active = active_p1;

endmodule

// File: tb/tb_mod_envelope_gen.sv
// Testbench for mod_envelope_gen: directed ADSR sequences followed by
// randomized ticks, gates and step values, checked by a scoreboard fed from a
// behavioural envelope model.
module tb_mod_envelope_gen;

    localparam int     WIDTH = 32;
    localparam int     POINT = 8;
    localparam longint ONE   = 256;

    localparam int S_IDLE = 0;
    localparam int S_ATT  = 1;
    localparam int S_DEC  = 2;
    localparam int S_SUS  = 3;
    localparam int S_REL  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick;
    logic             gate;
    logic [WIDTH-1:0] attack;
    logic [WIDTH-1:0] decay;
    logic [WIDTH-1:0] sustain;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] level;
    logic             valid;
    logic [2:0]       state;
    logic             active;

    always #5 clk = ~clk;

    mod_envelope_gen #(
        .WIDTH(WIDTH),
        .POINT(POINT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_tick   (tick),
        .i_gate   (gate),
        .i_attack (attack),
        .i_decay  (decay),
        .i_sustain(sustain),
        .i_release(rel),
        .o_level  (level),
        .o_valid  (valid),
        .o_state  (state),
        .o_active (active)
    );

    typedef struct {
        longint lvl;
        int     st;
        bit     act;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Envelope model state
    longint m_lvl  = 0;
    int     m_st   = S_IDLE;
    bit     m_gate = 1'b0;

    logic [WIDTH-1:0] cur_a, cur_d, cur_s, cur_r;

    function automatic void check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // One envelope update following the ADSR rules, using plain integers.
    task automatic model_tick(input bit g, input longint a, input longint d,
                              input longint s, input longint r);
        longint sus;
        bit     rise;
        bit     fall;
        exp_t   e;
        sus    = (s > ONE) ? ONE : s;
        rise   = g && !m_gate;
        fall   = !g && m_gate;
        m_gate = g;
        if (rise) m_st = S_ATT;
        else if (fall && (m_st == S_ATT || m_st == S_DEC || m_st == S_SUS)) m_st = S_REL;
        case (m_st)
            S_ATT: begin
                if (a == 0 || m_lvl + a >= ONE) begin m_lvl = ONE; m_st = S_DEC; end
                else m_lvl = m_lvl + a;
            end
            S_DEC: begin
                if (d == 0 || m_lvl - d <= sus) begin m_lvl = sus; m_st = S_SUS; end
                else m_lvl = m_lvl - d;
            end
            S_SUS: m_lvl = sus;
            S_REL: begin
                if (r == 0 || m_lvl <= r) begin m_lvl = 0; m_st = S_IDLE; end
                else m_lvl = m_lvl - r;
            end
            default: m_lvl = 0;
        endcase
        e.lvl = m_lvl;
        e.st  = m_st;
        e.act = (m_st != S_IDLE);
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs just after the rising edge; the DUT samples them
    // on the next rising edge.
    task automatic drive(input bit t, input bit g);
        @(posedge clk);
        #1;
        tick    = t;
        gate    = g;
        attack  = cur_a;
        decay   = cur_d;
        sustain = cur_s;
        rel     = cur_r;
        if (t) model_tick(g, longint'(cur_a), longint'(cur_d), longint'(cur_s), longint'(cur_r));
    endtask

    function automatic logic [WIDTH-1:0] rand_step();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return $urandom;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom_range(1, 90);
        endcase
    endfunction

    // Monitor: every output update is matched against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("level", longint'(level), e.lvl);
                    check("state", longint'(state), longint'(e.st));
                    check("active", longint'(active), longint'(e.act));
                end
            end
        end
    end

    initial begin : stim
        bit g;
        rst_n = 1'b0;
        tick  = 1'b0;
        gate  = 1'b0;
        cur_a = '0; cur_d = '0; cur_s = '0; cur_r = '0;
        attack = '0; decay = '0; sustain = '0; rel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", longint'(level), 0);
        check("rst_valid", longint'(valid), 0);
        check("rst_state", longint'(state), S_IDLE);
        check("rst_active", longint'(active), 0);
        rst_n = 1'b1;

        // Attack 64 per tick up to unity, then decay 32 to sustain 200.
        cur_a = 64; cur_d = 32; cur_s = 200; cur_r = 100;
        repeat (4) drive(1, 1);
        drive(0, 1);
        check("attack_peak", longint'(level), 256);
        check("attack_to_decay", longint'(state), S_DEC);
        repeat (2) drive(1, 1);
        drive(0, 1);
        check("decay_clamp", longint'(level), 200);
        check("decay_to_sus", longint'(state), S_SUS);
        repeat (3) drive(1, 1);
        drive(0, 1);
        check("sustain_hold", longint'(level), 200);

        // Release 100 per tick down to zero.
        drive(1, 0);
        drive(0, 0);
        check("release_step", longint'(level), 100);
        drive(1, 0);
        drive(0, 0);
        check("release_end", longint'(level), 0);
        check("release_idle", longint'(state), S_IDLE);
        check("release_inactive", longint'(active), 0);

        // Retrigger from RELEASE at level 100.
        repeat (6) drive(1, 1);
        drive(1, 0);
        drive(1, 1);
        drive(0, 1);
        check("retrigger_level", longint'(level), 164);
        check("retrigger_state", longint'(state), S_ATT);

        // Instant attack, then sustain above unity.
        drive(1, 0);
        drive(1, 0);
        cur_a = 0;
        drive(1, 1);
        drive(0, 1);
        check("instant_attack", longint'(level), 256);
        cur_s = 300;
        repeat (3) drive(1, 1);
        drive(0, 1);
        check("sus_over_one", longint'(level), 256);
        check("sus_over_one_st", longint'(state), S_SUS);

        // Gate toggles with no tick leave everything untouched.
        drive(0, 0); drive(0, 1); drive(0, 0); drive(0, 1);
        check("gate_no_tick_lvl", longint'(level), 256);
        check("gate_no_tick_st", longint'(state), S_SUS);

        // Async reset in the middle of ATTACK at level 128.
        cur_r = 0;
        drive(1, 0);
        cur_a = 64; cur_s = 200;
        repeat (2) drive(1, 1);
        drive(0, 1);
        check("pre_reset_level", longint'(level), 128);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_level", longint'(level), 0);
        check("areset_state", longint'(state), S_IDLE);
        check("areset_valid", longint'(valid), 0);
        check("areset_active", longint'(active), 0);
        sb.delete();
        m_lvl = 0; m_st = S_IDLE; m_gate = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Randomized phase: bursts of ticks, occasional gate flips and new steps.
        g = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                cur_a = rand_step();
                cur_d = rand_step();
                cur_r = rand_step();
                cur_s = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 320);
            end
            if ($urandom_range(0, 15) == 0) g = ~g;
            drive(((i / 64) % 3 == 0) ? 1'b1 : ($urandom_range(0, 2) != 0), g);
        end

        drive(0, g);
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
